// File: rtl/xcorr_peak_engine.sv
// Sliding-window cross-correlation with sequential peak search over lags -D..+D.
// Define XCORR_ABS_PEAK_EN to rank lags by |xCorr| instead of signed xCorr.
module xcorr_peak_engine #(
   parameter int NUM_BITS_SAMPLE   = 12,
   parameter int NUM_SAMPLES       = 100,
   parameter int MAX_SAMPLES_DELAY = 11,
   parameter int NUM_BITS_XCORR    = 2*NUM_BITS_SAMPLE + $clog2(NUM_SAMPLES),
   parameter int NUM_BITS_LAG      = $clog2(MAX_SAMPLES_DELAY+1) + 1
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            sampleValid,
   output logic                                            sampleReady,
   input  logic signed [NUM_BITS_SAMPLE-1:0]               sampleF,
   input  logic signed [NUM_BITS_SAMPLE-1:0]               sampleG,
   output logic [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0] xCorr,
   output logic                                            xCorrValid,
   output logic signed [NUM_BITS_LAG-1:0]                  peakLag,
   output logic signed [NUM_BITS_XCORR-1:0]                peakValue,
   output logic                                            peakValid
);

   localparam int W  = NUM_BITS_SAMPLE;
   localparam int N  = NUM_SAMPLES;
   localparam int D  = MAX_SAMPLES_DELAY;
   localparam int XW = NUM_BITS_XCORR;
   localparam int NL = 2*D + 1;
   localparam int FD = N + D;
   localparam int GD = N + 2*D;
   localparam int CW = $clog2(GD + 1);
   localparam int KW = $clog2(NL + 1);
   localparam logic [CW-1:0] FULL = CW'(GD);
   localparam logic [KW-1:0] LAST = KW'(NL - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, state_nxt;

   logic signed [W-1:0]  fh    [FD];
   logic signed [W-1:0]  gh    [GD];
   logic signed [W-1:0]  gwin  [NL];
   logic signed [XW-1:0] acc   [NL];
   logic signed [XW-1:0] delta [NL];
   logic signed [W-1:0]  fc, fo;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic                 accept;
   logic [KW-1:0]        kidx, best_k, win_k;
   logic signed [XW-1:0] best_val, cand, win_val;
   logic                 take;

   function automatic logic signed [XW:0] metric(input logic signed [XW-1:0] v);
      logic signed [XW:0] e;
      e = (XW+1)'(v);
`ifdef XCORR_ABS_PEAK_EN
      if (v < 0) e = -e;
`endif
      return e;
   endfunction

   assign accept     = sampleValid && sampleReady;
   assign cnt_nxt    = (cnt == FULL) ? cnt : cnt + 1'b1;
   assign xCorrValid = (cnt == FULL);

   // f[c] is D samples old; with D == 0 it is the sample being accepted
   if (D > 0) begin : g_fc_hist
      assign fc = fh[D-1];
   end else begin : g_fc_new
      assign fc = sampleF;
   end
   assign fo = fh[FD-1];

   // Operands include the incoming pair: gwin[j] = g[t-j], gh[j] = g[t-1-j]
   always_comb begin
      gwin[0] = sampleG;
      for (int unsigned j = 1; j < NL; j++) gwin[j] = gh[j-1];
      for (int unsigned k = 0; k < NL; k++) begin
         delta[k] = XW'(fc) * XW'(gwin[NL-1-k]) - XW'(fo) * XW'(gh[GD-1-k]);
         xCorr[k] = acc[k];
      end
   end

   always_comb begin
      cand    = acc[kidx];
      take    = (kidx == '0) || (metric(cand) > metric(best_val));
      win_val = take ? cand : best_val;
      win_k   = take ? kidx : best_k;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < FD; i++) fh[i] <= '0;
         for (int unsigned i = 0; i < GD; i++) gh[i] <= '0;
         for (int unsigned k = 0; k < NL; k++) acc[k] <= '0;
         cnt       <= '0;
         kidx      <= '0;
         best_k    <= '0;
         best_val  <= '0;
         peakLag   <= '0;
         peakValue <= '0;
      end else begin
         if (accept) begin
            fh[0] <= sampleF;
            for (int unsigned i = 1; i < FD; i++) fh[i] <= fh[i-1];
            gh[0] <= sampleG;
            for (int unsigned i = 1; i < GD; i++) gh[i] <= gh[i-1];
            for (int unsigned k = 0; k < NL; k++) acc[k] <= acc[k] + delta[k];
            cnt <= cnt_nxt;
         end
         if (state == SCAN) begin
            best_val <= win_val;
            best_k   <= win_k;
            if (kidx == LAST) begin
               kidx      <= '0;
               peakValue <= win_val;
               peakLag   <= NUM_BITS_LAG'(int'(win_k) - D);
            end else begin
               kidx <= kidx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      sampleReady = 1'b0;
      peakValid   = 1'b0;
      case (state)
         IDLE: begin
            sampleReady = 1'b1;
            if (sampleValid && (cnt_nxt == FULL)) state_nxt = SCAN;
         end
         SCAN: if (kidx == LAST) state_nxt = DONE;
         DONE: begin
            peakValid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_xcorr_peak_engine.sv
// Randomized self-checking bench for xcorr_peak_engine (N=8, D=2, W=4) against
// a direct-summation correlation model; honours XCORR_ABS_PEAK_EN.
module tb_xcorr_peak_engine;

   localparam int W  = 4;
   localparam int N  = 8;
   localparam int D  = 2;
   localparam int XW = 2*W + $clog2(N);
   localparam int LW = $clog2(D+1) + 1;
   localparam int NL = 2*D + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sampleValid = 1'b0;
   logic sampleReady, xCorrValid, peakValid;
   logic signed [W-1:0] sampleF = '0;
   logic signed [W-1:0] sampleG = '0;
   logic [NL-1:0][XW-1:0] xCorr;
   logic signed [LW-1:0] peakLag;
   logic signed [XW-1:0] peakValue;

   int checks = 0;
   int errors = 0;
   int fq[$];
   int gq[$];

   always #5 clk = ~clk;

   xcorr_peak_engine #(
      .NUM_BITS_SAMPLE(W),
      .NUM_SAMPLES(N),
      .MAX_SAMPLES_DELAY(D),
      .NUM_BITS_XCORR(XW),
      .NUM_BITS_LAG(LW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sampleValid(sampleValid),
      .sampleReady(sampleReady),
      .sampleF(sampleF),
      .sampleG(sampleG),
      .xCorr(xCorr),
      .xCorrValid(xCorrValid),
      .peakLag(peakLag),
      .peakValue(peakValue),
      .peakValid(peakValid)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // xCorr[k] = sum over the N most recent centre samples of f[n]*g[n+k-D]
   function automatic int model_x(input int k);
      int t = fq.size() - 1;
      int c = t - D;
      int s = 0;
      for (int n = c - N + 1; n <= c; n++) begin
         int m = n + k - D;
         if (n >= 0 && m >= 0 && m <= t) s += fq[n] * gq[m];
      end
      return s;
   endfunction

   function automatic int rank(input int v);
`ifdef XCORR_ABS_PEAK_EN
      return (v < 0) ? -v : v;
`else
      return v;
`endif
   endfunction

   task automatic model_peak(output int lag, output int val);
      int bk = 0;
      int bv = model_x(0);
      for (int k = 1; k < NL; k++) begin
         int v = model_x(k);
         if (rank(v) > rank(bv)) begin
            bk = k;
            bv = v;
         end
      end
      lag = bk - D;
      val = bv;
   endtask

   function automatic int xc(input int k);
      logic signed [XW-1:0] tmp;
      tmp = xCorr[k];
      return int'(tmp);
   endfunction

   task automatic check_xcorr(input string tag);
      for (int k = 0; k < NL; k++)
         check($sformatf("%s_xcorr%0d", tag, k), xc(k), model_x(k));
      check($sformatf("%s_xcorrvalid", tag), xCorrValid, (fq.size() >= N + 2*D) ? 1 : 0);
   endtask

   task automatic do_reset();
      sampleValid = 1'b0;
      sampleF = '0;
      sampleG = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      fq.delete();
      gq.delete();
      @(negedge clk);
      check("rst_ready", sampleReady, 1);
      check("rst_xvalid", xCorrValid, 0);
      check("rst_pvalid", peakValid, 0);
      check("rst_lag", peakLag, 0);
      check("rst_value", peakValue, 0);
      for (int k = 0; k < NL; k++) check($sformatf("rst_xcorr%0d", k), xc(k), 0);
   endtask

   // Entered away from a rising edge; returns at the falling edge after the accept
   task automatic send(input int f, input int g, input bit keep);
      int r;
      int waited = 0;
      sampleF = W'(f);
      sampleG = W'(g);
      sampleValid = 1'b1;
      while (1) begin
         r = sampleReady;
         @(posedge clk);
         if (r != 0) break;
         waited++;
         if (waited > 50) begin
            check("send_timeout", waited, 0);
            sampleValid = 1'b0;
            return;
         end
      end
      fq.push_back(f);
      gq.push_back(g);
      #1 if (!keep) sampleValid = 1'b0;
      @(negedge clk);
      check_xcorr("acc");
   endtask

   task automatic idle(input int n);
      sampleValid = 1'b0;
      repeat (n) @(negedge clk);
      check_xcorr("idle");
   endtask

   // Entered at the falling edge of the first cycle after a full-window accept
   task automatic watch_scan(input string tag);
      int low = 0;
      int pv_at = -1;
      int pv_cnt = 0;
      int lag, val;
      model_peak(lag, val);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (sampleReady) break;
         low++;
         if (peakValid) begin
            pv_cnt++;
            pv_at = cyc;
            check({tag, "_lag"}, peakLag, lag);
            check({tag, "_value"}, peakValue, val);
         end
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, low, 2*D + 2);
      check({tag, "_pulse_cycle"}, pv_at, 2*D + 2);
      check({tag, "_pulse_count"}, pv_cnt, 1);
      check({tag, "_hold_lag"}, peakLag, lag);
      check({tag, "_hold_value"}, peakValue, val);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pv_seen;

      // Reset
      do_reset();

      // Delay detection: g lags f by one sample
      for (int i = 0; i < N + 2*D; i++) begin
         send((i == 3) ? 7 : 0, (i == 4) ? 7 : 0, 1'b0);
         if (i < N + 2*D - 1) check("warm_ready", sampleReady, 1);
      end
      check("s2_xvalid", xCorrValid, 1);
      check("s2_peak_bin", xc(D + 1), 49);
      watch_scan("s2");
      check("s2_lag_const", peakLag, 1);
      check("s2_value_const", peakValue, 49);

      // Window expiry
      for (int i = 0; i < N; i++) begin
         send(0, 0, 1'b0);
         watch_scan("s3");
      end
      for (int k = 0; k < NL; k++) check($sformatf("s3_zero%0d", k), xc(k), 0);
      check("s3_lag_const", peakLag, -D);
      check("s3_value_const", peakValue, 0);

      // Handshake with sampleValid held high
      for (int i = 0; i < 6; i++) begin
         send($urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8, 1'b1);
         watch_scan("s4");
      end
      sampleValid = 1'b0;

      // Random traffic with gaps, through warm-up into steady state
      do_reset();
      for (int i = 0; i < 30; i++) begin
         send($urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8, 1'($urandom_range(0, 1)));
         if (fq.size() >= N + 2*D) watch_scan("rnd");
         else if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      sampleValid = 1'b0;

      // Sign handling: anti-correlated pair at zero lag
      do_reset();
      for (int i = 0; i < N + 2*D; i++)
         send((i == 5) ? 7 : 0, (i == 5) ? -7 : 0, 1'b0);
      watch_scan("s5");
`ifdef XCORR_ABS_PEAK_EN
      check("s5_lag_const", peakLag, 0);
      check("s5_value_const", peakValue, -49);
`else
      check("s5_lag_const", peakLag, -D);
      check("s5_value_const", peakValue, 0);
`endif

      // Reset during the third scan cycle
      pv_seen = 0;
      send(1, 1, 1'b0);
      if (peakValid) pv_seen++;
      @(negedge clk);
      if (peakValid) pv_seen++;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      if (peakValid) pv_seen++;
      @(posedge clk);
      #1 rst = 1'b0;
      fq.delete();
      gq.delete();
      @(negedge clk);
      check("s6_ready", sampleReady, 1);
      check("s6_xvalid", xCorrValid, 0);
      check("s6_lag", peakLag, 0);
      check("s6_value", peakValue, 0);
      for (int k = 0; k < NL; k++) check($sformatf("s6_xcorr%0d", k), xc(k), 0);
      for (int c = 0; c < 10; c++) begin
         if (peakValid) pv_seen++;
         @(negedge clk);
      end
      check("s6_no_pulse", pv_seen, 0);
      check("s6_ready_after", sampleReady, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xcorr_peak_engine.md
# xcorr_peak_engine

Sliding-window cross-correlation engine that accepts one signed sample pair (f, g) per handshake and keeps its own sample history. It updates 2·MAX_SAMPLES_DELAY+1 lag sums incrementally over a window of NUM_SAMPLES samples, then scans the lags sequentially and reports the peak lag and its value. It sits between the per-channel ADC sample stream and the direction-of-arrival logic. It replaces externally fed add/subtract operands with internal delay lines, a ready/valid handshake, warm-up tracking and peak search.

## Interface
- NUM_BITS_SAMPLE, 12, width of each signed sample
- NUM_SAMPLES, 100, window length N
- MAX_SAMPLES_DELAY, 11, max lag D; lags −D..+D
- NUM_BITS_XCORR, 2*NUM_BITS_SAMPLE+$clog2(NUM_SAMPLES), signed width of each lag sum
- NUM_BITS_LAG, $clog2(MAX_SAMPLES_DELAY+1)+1, signed width of peakLag
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sampleValid  in  1  sample pair offered
- sampleReady  out  1  engine can accept a pair
- sampleF  in  NUM_BITS_SAMPLE  signed reference-channel sample
- sampleG  in  NUM_BITS_SAMPLE  signed compared-channel sample
- xCorr  out  (2D+1)×NUM_BITS_XCORR  signed lag sums; index k ↔ lag k−D
- xCorrValid  out  1  window full; xCorr is a complete N-sample estimate
- peakLag  out  NUM_BITS_LAG  signed lag of the winning index
- peakValue  out  NUM_BITS_XCORR  signed xCorr value at peakLag
- peakValid  out  1  one-cycle pulse: peakLag and peakValue are updated

## Operation
- Accept when sampleValid && sampleReady. Then f history (depth N+D) and g history (depth N+2D) shift in the new samples. Histories reset to zero.
- Centre index c = t−D, where t is the newest accepted sample. Definition: xCorr[k] = Σ_{n=c−N+1..c} f[n]·g[n+k−D].
- Incremental update per accept, for every k: xCorr[k] += f[c]·g[c+k−D] − f[c−N]·g[c−N+k−D]. Operands are read from the history including the new sample.
- Arithmetic is signed two's complement. Products are 2·NUM_BITS_SAMPLE wide, sign-extended to NUM_BITS_XCORR. The sums cannot overflow for N samples.
- Zero-initialised history makes partial sums exact during warm-up.
- Warm-up counter saturates at N+2D accepted samples. xCorrValid = 1 once the counter reaches it, and stays 1 until reset.
- FSM states:
  - IDLE: sampleReady = 1. An accept goes to SCAN if the post-accept count is ≥ N+2D; otherwise it stays in IDLE.
  - SCAN: sampleReady = 0. Visits k = 0..2D, one per cycle. Strict greater-than compare, so ties go to the lowest k (most negative lag). After k = 2D, go to DONE.
  - DONE: sampleReady = 0. peakValid = 1 for this cycle, then go to IDLE.
- peakLag and peakValue hold their value between pulses.

## Timing
- Reset values:
  - xCorr, history, count, peakLag, peakValue: 0
  - xCorrValid, peakValid: 0
  - sampleReady: 1
  - state: IDLE
- rst wins over everything, including mid-SCAN. The scan is aborted and no peakValid is issued.
- xCorr latency: an accept at edge E makes the new xCorr visible in the cycle after E.
- SCAN occupies 2D+1 cycles, then DONE occupies 1. peakValid is high 2D+2 cycles after the accept edge.
- Full-window throughput: one accept per 2D+3 cycles. Warm-up throughput: one accept per cycle.
- sampleValid held high while sampleReady = 0 is not consumed. The data must stay stable until accepted.
- The warm-up counter does not wrap.

## Configuration
- XCORR_ABS_PEAK_EN defined: the compare uses |xCorr[k]|, so strong anti-correlation can win. peakValue still reports the signed value.
- XCORR_ABS_PEAK_EN undefined: the compare uses the signed xCorr[k], so the maximum positive value wins.

## Test plan
Scenarios 1–5 use N=8, D=2, W=4.
1. Reset: assert rst for 2 cycles → all outputs 0, sampleReady = 1, xCorrValid = 0.
2. Delay detection:
   - Stimulus: f = +7 impulse at sample 3 (others 0); g = +7 impulse at sample 4; 12 accepts total.
   - Required: xCorrValid rises on the 12th accept; peakLag = +1, peakValue = 49, all other lags 0.
3. Window expiry: after scenario 2, feed 8 zero pairs → all xCorr return to 0. The peak reports peakLag = −2, peakValue = 0.
4. Handshake: sampleValid held high with the window full → sampleReady is low for exactly 6 cycles after each accept. peakValid pulses 6 cycles after the accept edge. No sample is dropped or duplicated.
5. Sign and abs mode:
   - Stimulus: f = +7 and g = −7 at the same sample; window full.
   - Without the macro: peakLag = −2, peakValue = 0.
   - With XCORR_ABS_PEAK_EN: peakLag = 0, peakValue = −49.
6. Reset mid-scan: assert rst in the 3rd SCAN cycle → no peakValid. Next cycle: reset values, sampleReady = 1, xCorrValid = 0.
